// File: rtl/mem_word_master.sv
// mem_word_master: turns one 16-bit or 8-bit core request into little-endian byte
// accesses on a memory with one-cycle registered read latency.
module mem_word_master #(
    parameter int ADDR_W = 16
) (
    input  logic              mwm_clk,
    input  logic              mwm_rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [7:0]        mem_wdata_out,
    input  logic [7:0]        mem_rdata_in,
    output logic              mem_rd_en,
    output logic              mem_wr_en
);
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wd_hi_q;
    logic [7:0]        lo_q;
    logic              byte_q;
    // Outputs are registered for the state being entered, so each cycle's
    // memory strobes come straight from flops.
    always_ff @(posedge mwm_clk) begin
        if (mwm_rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wd_hi_q       <= '0;
            lo_q          <= '0;
            byte_q        <= 1'b0;
            cpu_rdata     <= '0;
            cpu_ready     <= 1'b1;
            cpu_done      <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
        end else begin
            cpu_ready     <= 1'b0;
            cpu_done      <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b1;
                    if (cpu_req) begin
                        addr_q        <= cpu_addr;
                        wd_hi_q       <= cpu_wdata[15:8];
                        byte_q        <= cpu_byte;
                        cpu_ready     <= 1'b0;
                        state         <= cpu_we ? WR_LO : RD_LO;
                        mem_addr_out  <= cpu_addr;
                        mem_wdata_out <= cpu_we ? cpu_wdata[7:0] : 8'h00;
                        mem_wr_en     <= cpu_we;
                        mem_rd_en     <= !cpu_we;
                    end
                end
                RD_LO: begin
                    state        <= byte_q ? RD_CAP : RD_HI;
                    mem_addr_out <= byte_q ? '0 : addr_q + ADDR_W'(1);
                    mem_rd_en    <= !byte_q;
                end
                RD_HI: begin
                    lo_q  <= mem_rdata_in;
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    cpu_rdata <= byte_q ? {8'h00, mem_rdata_in} : {mem_rdata_in, lo_q};
                    cpu_done  <= 1'b1;
                    state     <= DONE;
                end
                WR_LO: begin
                    state         <= byte_q ? DONE : WR_HI;
                    cpu_done      <= byte_q;
                    mem_addr_out  <= byte_q ? '0 : addr_q + ADDR_W'(1);
                    mem_wdata_out <= byte_q ? 8'h00 : wd_hi_q;
                    mem_wr_en     <= !byte_q;
                end
                WR_HI: begin
                    cpu_done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_word_master.sv
// tb_mem_word_master: randomized word/byte traffic against a byte-array reference model.
module tb_mem_word_master;
    logic        mwm_clk = 1'b0;
    logic        mwm_rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_byte = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_wdata_out;
    logic [7:0]  mem_rdata_in = '0;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  tb_mem  [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        prev_done = 1'b0;
    int          vectors = 0;
    int          errors = 0;

    mem_word_master #(.ADDR_W(16)) dut (
        .mwm_clk(mwm_clk), .mwm_rst(mwm_rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_byte(cpu_byte), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en)
    );

    always #5 mwm_clk = ~mwm_clk;

    // Byte-wide memory with one-cycle registered read data.
    always @(posedge mwm_clk) begin
        if (mem_wr_en) tb_mem[mem_addr_out] <= mem_wdata_out;
        if (mem_rd_en) mem_rdata_in <= tb_mem[mem_addr_out];
    end

    always @(negedge mwm_clk) begin
        vectors <= vectors + 1;
        if ((mem_rd_en && mem_wr_en) || (cpu_done && prev_done) || (cpu_done && cpu_ready)) begin
            errors <= errors + 1;
            $display("FAIL protocol: rd=%0b wr=%0b done=%0b prev_done=%0b ready=%0b",
                     mem_rd_en, mem_wr_en, cpu_done, prev_done, cpu_ready);
        end
        prev_done <= cpu_done;
    end

    task automatic wait_ready();
        int k = 0;
        @(negedge mwm_clk);
        while (!cpu_ready && k < 20) begin
            @(negedge mwm_clk);
            k++;
        end
        vectors++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b required 1", cpu_ready);
        end
    endtask

    task automatic do_op(input logic we, input logic bm, input logic [15:0] a,
                         input logic [15:0] wd, input logic busy);
        int lat, got;
        logic [15:0] a1, exp_rd;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd;
        logic        exp_en;
        lat = we ? (bm ? 2 : 3) : (bm ? 3 : 4);
        a1 = a + 16'd1;
        exp_rd = bm ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};
        wait_ready();
        cpu_req = 1'b1; cpu_we = we; cpu_byte = bm; cpu_addr = a; cpu_wdata = wd;
        @(posedge mwm_clk); #1;
        cpu_req = busy; cpu_we = busy ? 1'b1 : 1'($urandom);
        cpu_byte = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        got = 0;
        for (int c = 1; c <= 8; c++) begin
            exp_en   = (c == 1) || (c == 2 && !bm);
            exp_addr = (c == 1) ? a : (exp_en ? a1 : 16'h0000);
            exp_wd   = (!we || !exp_en) ? 8'h00 : (c == 1 ? wd[7:0] : wd[15:8]);
            vectors++;
            if (cpu_ready !== 1'b0 || (we ? mem_wr_en : mem_rd_en) !== exp_en ||
                (we ? mem_rd_en : mem_wr_en) !== 1'b0 || mem_addr_out !== exp_addr ||
                mem_wdata_out !== exp_wd) begin
                errors++;
                $display("FAIL cycle%0d we=%0b byte=%0b: ready=%b en=%b/%b addr=%h wd=%h required ready=0 en=%b addr=%h wd=%h",
                         c, we, bm, cpu_ready, mem_rd_en, mem_wr_en, mem_addr_out, mem_wdata_out,
                         exp_en, exp_addr, exp_wd);
            end
            if (cpu_done) begin
                got = c;
                cpu_req = 1'b0;
                break;
            end
            @(posedge mwm_clk); #1;
        end
        cpu_req = 1'b0;
        vectors++;
        if (got != lat) begin
            errors++;
            $display("FAIL done_latency we=%0b byte=%0b: got cycle %0d required %0d", we, bm, got, lat);
        end
        if (we) begin
            ref_mem[a] = wd[7:0];
            if (!bm) ref_mem[a1] = wd[15:8];
            vectors++;
            if (tb_mem[a] !== ref_mem[a] || tb_mem[a1] !== ref_mem[a1]) begin
                errors++;
                $display("FAIL write_mem @%h: mem=%h %h required %h %h", a, tb_mem[a], tb_mem[a1], ref_mem[a], ref_mem[a1]);
            end
        end else begin
            vectors++;
            if (cpu_rdata !== exp_rd) begin
                errors++;
                $display("FAIL read_data @%h byte=%0b: got %h required %h", a, bm, cpu_rdata, exp_rd);
            end
        end
        @(posedge mwm_clk); #1;
        vectors++;
        if (cpu_ready !== 1'b1 || cpu_done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: ready=%b done=%b required 1 0", cpu_ready, cpu_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge mwm_clk);
        #1 mwm_rst = 1'b0;
        @(negedge mwm_clk);
        vectors++;
        if (cpu_ready !== 1'b1 || cpu_done !== 1'b0 || cpu_rdata !== 16'h0 || mem_rd_en !== 1'b0 ||
            mem_wr_en !== 1'b0 || mem_addr_out !== 16'h0 || mem_wdata_out !== 8'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b rdata=%h rd=%b wr=%b addr=%h wd=%h",
                     cpu_ready, cpu_done, cpu_rdata, mem_rd_en, mem_wr_en, mem_addr_out, mem_wdata_out);
        end
    endtask

    task automatic test_word_write_read();
        do_op(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0);
        vectors++;
        if (tb_mem[16'h0010] !== 8'hEF || tb_mem[16'h0011] !== 8'hBE) begin
            errors++;
            $display("FAIL beef_bytes: got %h %h required ef be", tb_mem[16'h0010], tb_mem[16'h0011]);
        end
        do_op(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        vectors++;
        if (cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL beef_read: got %h required beef", cpu_rdata);
        end
    endtask

    task automatic test_byte_read();
        tb_mem[16'h0006] = 8'h47; tb_mem[16'h0007] = 8'h8E;
        ref_mem[16'h0006] = 8'h47; ref_mem[16'h0007] = 8'h8E;
        do_op(1'b0, 1'b1, 16'h0006, 16'h0000, 1'b0);
        do_op(1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0);
    endtask

    task automatic test_wrap();
        do_op(1'b1, 1'b0, 16'hFFFF, 16'h1234, 1'b0);
        vectors++;
        if (tb_mem[16'hFFFF] !== 8'h34 || tb_mem[16'h0000] !== 8'h12) begin
            errors++;
            $display("FAIL wrap_bytes: got %h %h required 34 12", tb_mem[16'hFFFF], tb_mem[16'h0000]);
        end
        do_op(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    endtask

    task automatic test_busy_reject();
        do_op(1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1);
        do_op(1'b0, 1'b1, 16'h0041, 16'h0000, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] hi_before;
        hi_before = tb_mem[16'h0021];
        wait_ready();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 16'hAABB;
        @(posedge mwm_clk); #1;
        cpu_req = 1'b0;
        @(negedge mwm_clk);
        mwm_rst = 1'b1;
        @(posedge mwm_clk); #1;
        mwm_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (cpu_done !== 1'b0 || cpu_ready !== 1'b1 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort c%0d: done=%b ready=%b wr=%b rd=%b required 0 1 0 0",
                         c, cpu_done, cpu_ready, mem_wr_en, mem_rd_en);
            end
            @(posedge mwm_clk); #1;
        end
        ref_mem[16'h0020] = 8'hBB;
        vectors++;
        if (tb_mem[16'h0020] !== 8'hBB || tb_mem[16'h0021] !== hi_before || cpu_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_write: mem=%h %h rdata=%h required bb %h 0000",
                     tb_mem[16'h0020], tb_mem[16'h0021], cpu_rdata, hi_before);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
            do_op(1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i] = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        test_reset();
        test_word_write_read();
        test_byte_read();
        test_wrap();
        test_busy_reject();
        test_reset_mid_write();
        test_random();
        @(negedge mwm_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
